// File: rtl/nios2_cpu_debug_host_shifter_if.sv
// Command/response bus between a debug host and the virtual-JTAG shifter.
interface nios2_cpu_debug_host_shifter_if #(
   parameter int unsigned DR_WIDTH = 38
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_ir;
   logic [DR_WIDTH-1:0] cmd_data;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_data;
   logic [1:0]          rsp_ir_out;

   // Host side: issues commands, consumes responses.
   modport master (
      output cmd_valid, cmd_ir, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
   );

   // Shifter side: accepts commands, produces responses.
   modport slave (
      input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
   );
endinterface

// File: rtl/nios2_cpu_debug_host_shifter.sv
// Initiator for the Nios II debug-slave virtual-JTAG port: runs one
// UIR/CDR/SDR/UDR sequence per command and returns the captured DR and IR status.
module nios2_cpu_debug_host_shifter #(
   parameter int unsigned DR_WIDTH = 38,
   parameter int unsigned TCK_DIV  = 2
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   nios2_cpu_debug_host_shifter_if.slave        host,
   output logic                                 vji_tck,
   output logic                                 vji_tdi,
   input  logic                                 vji_tdo,
   output logic [1:0]                           vji_ir_in,
   input  logic [1:0]                           vji_ir_out,
   output logic                                 vji_uir,
   output logic                                 vji_cdr,
   output logic                                 vji_sdr,
   output logic                                 vji_udr,
   output logic                                 vji_rti,
   output logic                                 busy
);

   localparam int unsigned PHASE_W = 8;
   localparam int unsigned BIT_W   = $clog2(DR_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_UIR  = 3'd1,
      S_CDR  = 3'd2,
      S_SDR  = 3'd3,
      S_UDR  = 3'd4,
      S_RESP = 3'd5
   } state_t;

   state_t              r_state,      w_state;
   logic [PHASE_W-1:0]  r_phase,      w_phase;
   logic [BIT_W-1:0]    r_bit,        w_bit;
   logic [DR_WIDTH-1:0] r_shift,      w_shift;
   logic                r_tck,        w_tck;
   logic                r_tdi,        w_tdi;
   logic [1:0]          r_ir_in,      w_ir_in;
   logic                r_uir,        w_uir;
   logic                r_cdr,        w_cdr;
   logic                r_sdr,        w_sdr;
   logic                r_udr,        w_udr;
   logic                r_rti,        w_rti;
   logic                r_busy,       w_busy;
   logic                r_cmd_ready,  w_cmd_ready;
   logic                r_rsp_valid,  w_rsp_valid;
   logic [DR_WIDTH-1:0] r_rsp_data,   w_rsp_data;
   logic [1:0]          r_rsp_ir_out, w_rsp_ir_out;
   logic                w_phase_end;
   logic                w_rise;
   logic                w_fall;

   // State, counters, shift register and every output flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_phase      <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_tck        <= 1'b0;
         r_tdi        <= 1'b0;
         r_ir_in      <= 2'b00;
         r_uir        <= 1'b0;
         r_cdr        <= 1'b0;
         r_sdr        <= 1'b0;
         r_udr        <= 1'b0;
         r_rti        <= 1'b1;
         r_busy       <= 1'b0;
         r_cmd_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_ir_out <= 2'b00;
      end else begin
         r_state      <= w_state;
         r_phase      <= w_phase;
         r_bit        <= w_bit;
         r_shift      <= w_shift;
         r_tck        <= w_tck;
         r_tdi        <= w_tdi;
         r_ir_in      <= w_ir_in;
         r_uir        <= w_uir;
         r_cdr        <= w_cdr;
         r_sdr        <= w_sdr;
         r_udr        <= w_udr;
         r_rti        <= w_rti;
         r_busy       <= w_busy;
         r_cmd_ready  <= w_cmd_ready;
         r_rsp_valid  <= w_rsp_valid;
         r_rsp_data   <= w_rsp_data;
         r_rsp_ir_out <= w_rsp_ir_out;
      end
   end

   // Next state; TCK rises mid-period (sample point) and falls at the period
   // boundary, which is the only place the virtual state may advance.
   always_comb begin
      w_state      = r_state;
      w_phase      = r_phase;
      w_bit        = r_bit;
      w_shift      = r_shift;
      w_tck        = r_tck;
      w_tdi        = r_tdi;
      w_ir_in      = r_ir_in;
      w_rsp_data   = r_rsp_data;
      w_rsp_ir_out = r_rsp_ir_out;
      w_phase_end  = (r_phase == PHASE_W'(TCK_DIV - 1));
      w_rise       = 1'b0;
      w_fall       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (host.cmd_valid && r_cmd_ready) begin
               w_state = S_UIR;
               w_shift = host.cmd_data;
               w_ir_in = host.cmd_ir;
               w_phase = '0;
               w_tck   = 1'b0;
            end
         end
         S_UIR, S_CDR, S_SDR, S_UDR: begin
            w_rise  = w_phase_end && !r_tck;
            w_fall  = w_phase_end && r_tck;
            w_phase = w_phase_end ? '0 : r_phase + PHASE_W'(1);
            if (w_phase_end) begin
               w_tck = !r_tck;
            end
            if (w_rise && (r_state == S_UIR)) begin
               w_rsp_ir_out = vji_ir_out;
            end
            if (w_rise && (r_state == S_SDR)) begin
               w_shift = {vji_tdo, r_shift[DR_WIDTH-1:1]};
            end
            if (w_fall) begin
               case (r_state)
                  S_UIR: w_state = S_CDR;
                  S_CDR: begin
                     w_state = S_SDR;
                     w_bit   = '0;
                  end
                  S_SDR: begin
                     if (r_bit == BIT_W'(DR_WIDTH - 1)) begin
                        w_state = S_UDR;
                     end else begin
                        w_bit = r_bit + BIT_W'(1);
                     end
                  end
                  default: begin
                     w_state    = S_RESP;
                     w_rsp_data = r_shift;
                  end
               endcase
               // r_shift already holds this period's shift, so bit 0 is the next TDI.
               w_tdi = (w_state == S_SDR) ? r_shift[0] : 1'b0;
            end
         end
         S_RESP: begin
            if (host.rsp_ready) begin
               w_state = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase

      w_uir       = (w_state == S_UIR);
      w_cdr       = (w_state == S_CDR);
      w_sdr       = (w_state == S_SDR);
      w_udr       = (w_state == S_UDR);
      w_rti       = (w_state == S_IDLE) || (w_state == S_RESP);
      w_busy      = (w_state != S_IDLE);
      w_cmd_ready = (w_state == S_IDLE);
      w_rsp_valid = (w_state == S_RESP);
   end

   assign host.cmd_ready  = r_cmd_ready;
   assign host.rsp_valid  = r_rsp_valid;
   assign host.rsp_data   = r_rsp_data;
   assign host.rsp_ir_out = r_rsp_ir_out;
   assign vji_tck         = r_tck;
   assign vji_tdi         = r_tdi;
   assign vji_ir_in       = r_ir_in;
   assign vji_uir         = r_uir;
   assign vji_cdr         = r_cdr;
   assign vji_sdr         = r_sdr;
   assign vji_udr         = r_udr;
   assign vji_rti         = r_rti;
   assign busy            = r_busy;

endmodule

// File: tb/tb_nios2_cpu_debug_host_shifter.sv
// Directed bench: two shifter instances (38-bit/TCK_DIV=2 and 8-bit/TCK_DIV=1)
// talking to small virtual-JTAG slave models, responses checked via a scoreboard.
module tb_nios2_cpu_debug_host_shifter;

   localparam int unsigned DWA = 38;
   localparam int unsigned DWB = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  ir;
   } exp_t;
   exp_t sb[$];

   // ---------------- DUT A ----------------
   nios2_cpu_debug_host_shifter_if #(.DR_WIDTH(DWA)) ha ();
   logic       a_tck, a_tdi, a_tdo, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_busy;
   logic [1:0] a_ir_in;
   logic [1:0] a_ir_out = 2'b00;

   nios2_cpu_debug_host_shifter #(.DR_WIDTH(DWA), .TCK_DIV(2)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .host(ha),
      .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo),
      .vji_ir_in(a_ir_in), .vji_ir_out(a_ir_out),
      .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr),
      .vji_rti(a_rti), .busy(a_busy)
   );

   // ---------------- DUT B ----------------
   nios2_cpu_debug_host_shifter_if #(.DR_WIDTH(DWB)) hb ();
   logic       b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti, b_busy;
   logic [1:0] b_ir_in;
   logic [1:0] b_ir_out = 2'b00;

   nios2_cpu_debug_host_shifter #(.DR_WIDTH(DWB), .TCK_DIV(1)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .host(hb),
      .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo),
      .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out),
      .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr),
      .vji_rti(b_rti), .busy(b_busy)
   );

   // ---------------- slave model A ----------------
   logic           ma_load = 1'b0;
   logic [DWA-1:0] ma_load_val = '0;
   logic [DWA-1:0] ma_sr, ma_latch;
   logic [1:0]     ma_ir;
   logic           a_tck_d;
   int             ma_n_uir, ma_n_cdr, ma_n_sdr, ma_n_udr;
   assign a_tdo = ma_sr[0];

   // Slave reacts to each TCK rise; load also clears its period counters.
   always @(posedge clk) begin
      a_tck_d <= a_tck;
      if (ma_load) begin
         ma_sr    <= ma_load_val;
         ma_latch <= '0;
         ma_ir    <= 2'b00;
         ma_n_uir <= 0; ma_n_cdr <= 0; ma_n_sdr <= 0; ma_n_udr <= 0;
      end else if (a_tck && !a_tck_d) begin
         if (a_uir) begin ma_ir <= a_ir_in; ma_n_uir <= ma_n_uir + 1; end
         if (a_cdr) ma_n_cdr <= ma_n_cdr + 1;
         if (a_sdr) begin ma_sr <= {a_tdi, ma_sr[DWA-1:1]}; ma_n_sdr <= ma_n_sdr + 1; end
         if (a_udr) begin ma_latch <= ma_sr; ma_n_udr <= ma_n_udr + 1; end
      end
   end

   wire [4:0] a_strb = {a_uir, a_cdr, a_sdr, a_udr, a_rti};
   logic [4:0] a_strb_d = 5'b00001;
   int ma_bad_edge = 0;
   int ma_bad_excl = 0;

   // Strobe monitor: changes only with TCK low, always exactly one strobe.
   always @(negedge clk) begin
      a_strb_d <= a_strb;
      if (ma_load) begin
         ma_bad_edge <= 0;
         ma_bad_excl <= 0;
      end else begin
         if ((a_strb != a_strb_d) && a_tck) ma_bad_edge <= ma_bad_edge + 1;
         if (!$onehot(a_strb)) ma_bad_excl <= ma_bad_excl + 1;
      end
   end

   // ---------------- slave model B ----------------
   logic           mb_load = 1'b0;
   logic [DWB-1:0] mb_load_val = '0;
   logic [DWB-1:0] mb_sr, mb_latch;
   logic           b_tck_d;
   int             mb_n_sdr;
   assign b_tdo = mb_sr[0];

   // Slave B: same behaviour, 8-bit DR.
   always @(posedge clk) begin
      b_tck_d <= b_tck;
      if (mb_load) begin
         mb_sr    <= mb_load_val;
         mb_latch <= '0;
         mb_n_sdr <= 0;
      end else if (b_tck && !b_tck_d) begin
         if (b_sdr) begin mb_sr <= {b_tdi, mb_sr[DWB-1:1]}; mb_n_sdr <= mb_n_sdr + 1; end
         if (b_udr) mb_latch <= mb_sr;
      end
   end

   logic b_sdr_p = 1'b0;
   logic b_tck_p = 1'b0;
   int   mb_bad_tog = 0;

   // TCK must toggle on every clk cycle while B is shifting.
   always @(negedge clk) begin
      b_sdr_p <= b_sdr;
      b_tck_p <= b_tck;
      if (mb_load) mb_bad_tog <= 0;
      else if (b_sdr && b_sdr_p && (b_tck == b_tck_p)) mb_bad_tog <= mb_bad_tog + 1;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_a(input logic [DWA-1:0] v);
      @(negedge clk);
      ma_load = 1'b1; ma_load_val = v;
      @(negedge clk);
      ma_load = 1'b0;
   endtask

   task automatic issue_a(input logic [1:0] ir, input logic [DWA-1:0] d, output int unsigned acc);
      int k;
      @(negedge clk);
      ha.cmd_valid = 1'b1; ha.cmd_ir = ir; ha.cmd_data = d;
      k = 0;
      while (!ha.cmd_ready && k < 1000) begin @(negedge clk); k++; end
      check("accept_wait", 64'(ha.cmd_ready), 64'd1);
      @(negedge clk);
      acc = cyc;
      ha.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp_a();
      int k;
      k = 0;
      while (!ha.rsp_valid && k < 2000) begin @(negedge clk); k++; end
      check("rsp_wait_a", 64'(ha.rsp_valid), 64'd1);
   endtask

   task automatic pop_cmp(input string tag, input logic [63:0] data, input logic [1:0] ir);
      exp_t e;
      check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_data"}, data, e.data);
         check({tag, "_ir_out"}, 64'(ir), 64'(e.ir));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ctl"},
            64'({a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_busy, ha.rsp_valid, ha.cmd_ready}),
            64'(10'b0000001001));
      check({tag, "_ir_in"},  64'(a_ir_in), 64'd0);
      check({tag, "_rsp_data"}, 64'(ha.rsp_data), 64'd0);
      check({tag, "_rsp_ir"}, 64'(ha.rsp_ir_out), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int unsigned acc, acc2, h;
      int bad, k;

      ha.cmd_valid = 1'b0; ha.cmd_ir = 2'b00; ha.cmd_data = '0; ha.rsp_ready = 1'b0;
      hb.cmd_valid = 1'b0; hb.cmd_ir = 2'b00; hb.cmd_data = '0; hb.rsp_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset_n = 1'b1;

      // Loopback and strobe order.
      load_a(38'h12_3456_789A);
      a_ir_out = 2'b10;
      sb.push_back('{data: 64'h12_3456_789A, ir: 2'b10});
      issue_a(2'b01, 38'h01_0000_0001, acc);
      wait_rsp_a();
      check("latency_a", 64'(cyc - acc), 64'd164);
      pop_cmp("loopback", 64'(ha.rsp_data), ha.rsp_ir_out);
      check("model_latch", 64'(ma_latch), 64'h01_0000_0001);
      check("model_ir_in", 64'(ma_ir), 64'd1);
      check("n_uir", 64'(ma_n_uir), 64'd1);
      check("n_cdr", 64'(ma_n_cdr), 64'd1);
      check("n_sdr", 64'(ma_n_sdr), 64'd38);
      check("n_udr", 64'(ma_n_udr), 64'd1);
      check("strobe_tck_low", 64'(ma_bad_edge), 64'd0);
      check("strobe_onehot", 64'(ma_bad_excl), 64'd0);

      // Backpressure.
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (ha.rsp_valid !== 1'b1 || ha.rsp_data !== 38'h12_3456_789A ||
             ha.rsp_ir_out !== 2'b10 || a_tck !== 1'b0 || ha.cmd_ready !== 1'b0) bad++;
      end
      check("backpressure_stable", 64'(bad), 64'd0);
      ha.rsp_ready = 1'b1;
      @(negedge clk);
      ha.rsp_ready = 1'b0;
      check("hs_rsp_valid_drop", 64'(ha.rsp_valid), 64'd0);
      check("hs_cmd_ready_rise", 64'(ha.cmd_ready), 64'd1);

      // Back-to-back with cmd_valid held high.
      load_a(38'h2A_5A5A_C3C3);
      a_ir_out = 2'b01;
      sb.push_back('{data: 64'h2A_5A5A_C3C3, ir: 2'b01});
      sb.push_back('{data: 64'h15_F0F0_0FF0, ir: 2'b01});
      @(negedge clk);
      ha.rsp_ready = 1'b1;
      ha.cmd_valid = 1'b1; ha.cmd_ir = 2'b10; ha.cmd_data = 38'h15_F0F0_0FF0;
      @(negedge clk);
      acc = cyc;
      ha.cmd_ir = 2'b11; ha.cmd_data = 38'h0B_1234_4321;
      check("b2b_ir_first", 64'(a_ir_in), 64'd2);
      wait_rsp_a();
      check("b2b_latency1", 64'(cyc - acc), 64'd164);
      pop_cmp("b2b_first", 64'(ha.rsp_data), ha.rsp_ir_out);
      h = cyc;
      @(negedge clk);
      check("b2b_ready_after_hs", 64'(ha.cmd_ready), 64'd1);
      check("b2b_ir_held", 64'(a_ir_in), 64'd2);
      @(negedge clk);
      acc2 = cyc;
      ha.cmd_valid = 1'b0;
      check("b2b_second_accepted", 64'(ha.cmd_ready), 64'd0);
      check("b2b_ir_second", 64'(a_ir_in), 64'd3);
      check("b2b_accept_gap", 64'(acc2 - h), 64'd2);
      wait_rsp_a();
      check("b2b_latency2", 64'(cyc - acc2), 64'd164);
      pop_cmp("b2b_second", 64'(ha.rsp_data), ha.rsp_ir_out);
      @(negedge clk);
      ha.rsp_ready = 1'b0;
      check("b2b_model_latch", 64'(ma_latch), 64'h0B_1234_4321);

      // Reset in the middle of SDR.
      load_a(38'h33_CCCC_AAAA);
      issue_a(2'b00, 38'h00_1111_2222, acc);
      k = 0;
      while (ma_n_sdr < 10 && k < 500) begin @(negedge clk); k++; end
      check("reach_sdr10", 64'(ma_n_sdr), 64'd10);
      reset_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (ha.rsp_valid !== 1'b0 || a_udr !== 1'b0) bad++;
      end
      check("midreset_no_rsp", 64'(bad), 64'd0);
      check("midreset_no_udr", 64'(ma_n_udr), 64'd0);
      load_a(38'h1C_0DE0_BEEF);
      a_ir_out = 2'b11;
      sb.push_back('{data: 64'h1C_0DE0_BEEF, ir: 2'b11});
      issue_a(2'b01, 38'h27_7777_8888, acc);
      wait_rsp_a();
      check("fresh_latency", 64'(cyc - acc), 64'd164);
      pop_cmp("fresh", 64'(ha.rsp_data), ha.rsp_ir_out);
      ha.rsp_ready = 1'b1;
      @(negedge clk);
      ha.rsp_ready = 1'b0;
      check("fresh_model_latch", 64'(ma_latch), 64'h27_7777_8888);

      // DR_WIDTH=8, TCK_DIV=1 instance.
      @(negedge clk);
      mb_load = 1'b1; mb_load_val = 8'hA5;
      @(negedge clk);
      mb_load = 1'b0;
      b_ir_out = 2'b01;
      sb.push_back('{data: 64'hA5, ir: 2'b01});
      hb.cmd_valid = 1'b1; hb.cmd_ir = 2'b11; hb.cmd_data = 8'h3C;
      check("b_ready", 64'(hb.cmd_ready), 64'd1);
      @(negedge clk);
      acc = cyc;
      hb.cmd_valid = 1'b0;
      k = 0;
      while (!hb.rsp_valid && k < 200) begin @(negedge clk); k++; end
      check("rsp_wait_b", 64'(hb.rsp_valid), 64'd1);
      check("latency_b", 64'(cyc - acc), 64'd22);
      pop_cmp("small", 64'(hb.rsp_data), hb.rsp_ir_out);
      check("b_model_latch", 64'(mb_latch), 64'h3C);
      check("b_n_sdr", 64'(mb_n_sdr), 64'd8);
      check("b_tck_toggle", 64'(mb_bad_tog), 64'd0);
      hb.rsp_ready = 1'b1;
      @(negedge clk);
      hb.rsp_ready = 1'b0;
      check("b_idle_after", 64'(hb.cmd_ready), 64'd1);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
